// File: rtl/ipbase_dispatch_roundrobin.sv
// Round-robin dispatcher: one input beat per cycle goes to the first free output lane, scanning cyclically from a one-hot pointer.
// Latency 1 cycle to the lane register; s_ready drops only when every lane holds a beat its consumer is not taking.
module ipbase_dispatch_roundrobin #(
    parameter int NUM = 4,
    parameter int DW  = 8,
    parameter int CW  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    input  logic [DW-1:0]           s_data,
    output logic                    s_ready,
    output logic [NUM-1:0]          m_valid,
    output logic [NUM*DW-1:0]       m_data,
    input  logic [NUM-1:0]          m_ready,
    output logic [$clog2(NUM)-1:0]  s_lane,
    output logic [CW-1:0]           acc_cnt
);
    localparam int LW = $clog2(NUM);
    localparam logic [LW:0] NUM_L = NUM[LW:0];

    logic [NUM-1:0]    m_valid_q, m_valid_d;
    logic [NUM*DW-1:0] m_data_q,  m_data_d;
    logic [NUM-1:0]    prio_q,    prio_d;
    logic [CW-1:0]     acc_cnt_q, acc_cnt_d;

    logic [NUM-1:0] free;
    logic [LW-1:0]  ptr;
    logic [LW-1:0]  gnt;
    logic [LW:0]    idx;
    logic [LW:0]    nxt;
    logic           found;
    logic           accept;

    // Cyclic first-free search starting at the pointer lane, inclusive.
    always_comb begin
        free  = ~m_valid_q | m_ready;
        ptr   = '0;
        for (int i = 0; i < NUM; i++) begin
            if (prio_q[i]) ptr = i[LW-1:0];
        end
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < NUM; k++) begin
            idx = {1'b0, ptr} + k[LW:0];
            if (idx >= NUM_L) idx = idx - NUM_L;
            if (!found && free[idx[LW-1:0]]) begin
                found = 1'b1;
                gnt   = idx[LW-1:0];
            end
        end
        nxt = {1'b0, gnt} + {{LW{1'b0}}, 1'b1};
        if (nxt == NUM_L) nxt = '0;
    end

    assign s_ready = |free;
    assign s_lane  = gnt;
    assign accept  = s_valid & s_ready;

    // Draining lanes clear first; a grant on the same lane overrides, so a draining lane reloads without a bubble.
    always_comb begin
        m_valid_d = m_valid_q & ~m_ready;
        m_data_d  = m_data_q;
        prio_d    = prio_q;
        acc_cnt_d = acc_cnt_q;
        if (accept) begin
            m_valid_d[gnt]           = 1'b1;
            m_data_d[gnt*DW +: DW]   = s_data;
            prio_d                   = '0;
            prio_d[nxt[LW-1:0]]      = 1'b1;
            acc_cnt_d                = acc_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= '0;
            m_data_q  <= '0;
            prio_q    <= {{(NUM-1){1'b0}}, 1'b1};
            acc_cnt_q <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            prio_q    <= prio_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign acc_cnt = acc_cnt_q;
endmodule

// File: tb/tb_ipbase_dispatch_roundrobin.sv
module tb_ipbase_dispatch_roundrobin;
    logic        clk;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [3:0]  m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_ready;
    logic [1:0]  s_lane;
    logic [3:0]  acc_cnt;

    int checks;
    int failures;

    ipbase_dispatch_roundrobin #(.NUM(4), .DW(8), .CW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .s_lane  (s_lane),
        .acc_cnt (acc_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        sv;
        logic [7:0]  d;
        logic [3:0]  mr;
        logic        chk;
        logic        rdy;
        logic [1:0]  lane;
        logic [3:0]  mv;
        logic [31:0] md;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(logic r, logic sv, logic [7:0] d, logic [3:0] mr, logic chk,
                                logic rdy, logic [1:0] lane, logic [3:0] mv, logic [31:0] md,
                                logic [3:0] cnt);
        vec_t v;
        v.rst = r; v.sv = sv; v.d = d; v.mr = mr; v.chk = chk;
        v.rdy = rdy; v.lane = lane; v.mv = mv; v.md = md; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic [7:0] sb_q[$];
    int pushed;
    int popped;

    // Accept and drain bookkeeping at the falling edge, before the edge that commits them.
    task automatic sb_sample(string tag);
        logic [7:0] expd;
        if (s_valid && s_ready) begin
            sb_q.push_back(s_data);
            pushed++;
        end
        for (int l = 0; l < 4; l++) begin
            if (m_valid[l] && m_ready[l]) begin
                popped++;
                if (sb_q.size() == 0) begin
                    check($sformatf("%s_extra_beat_lane%0d", tag, l), 32'(m_data[l*8 +: 8]), 32'hFFFF_FFFF);
                end else begin
                    expd = sb_q.pop_front();
                    check($sformatf("%s_order_lane%0d", tag, l), 32'(m_data[l*8 +: 8]), 32'(expd));
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pushed   = 0;
        popped   = 0;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        m_ready  = 4'hF;

        //               rst sv  d      mr    chk rdy lane mv    md             cnt
        vecs[0]  = mk(1, 1, 8'hAA, 4'hF, 0, 0, 0, 4'b0000, 32'h00000000, 4'd0);
        vecs[1]  = mk(0, 1, 8'h10, 4'hF, 1, 1, 0, 4'b0001, 32'h00000010, 4'd1);
        vecs[2]  = mk(0, 1, 8'h11, 4'hF, 1, 1, 1, 4'b0010, 32'h00001110, 4'd2);
        vecs[3]  = mk(0, 1, 8'h12, 4'hF, 1, 1, 2, 4'b0100, 32'h00121110, 4'd3);
        vecs[4]  = mk(0, 1, 8'h13, 4'hF, 1, 1, 3, 4'b1000, 32'h13121110, 4'd4);
        vecs[5]  = mk(0, 1, 8'h14, 4'hF, 1, 1, 0, 4'b0001, 32'h13121114, 4'd5);
        vecs[6]  = mk(0, 1, 8'h15, 4'hF, 1, 1, 1, 4'b0010, 32'h13121514, 4'd6);
        vecs[7]  = mk(0, 1, 8'h16, 4'hF, 1, 1, 2, 4'b0100, 32'h13161514, 4'd7);
        vecs[8]  = mk(0, 1, 8'h17, 4'hF, 1, 1, 3, 4'b1000, 32'h17161514, 4'd8);
        vecs[9]  = mk(0, 1, 8'h20, 4'h0, 1, 1, 0, 4'b1001, 32'h17161520, 4'd9);
        vecs[10] = mk(0, 0, 8'hEE, 4'h8, 1, 1, 1, 4'b0001, 32'h17161520, 4'd9);
        vecs[11] = mk(0, 1, 8'h21, 4'h0, 1, 1, 1, 4'b0011, 32'h17162120, 4'd10);
        vecs[12] = mk(0, 1, 8'h22, 4'h0, 1, 1, 2, 4'b0111, 32'h17222120, 4'd11);
        vecs[13] = mk(0, 0, 8'hEE, 4'h2, 1, 1, 3, 4'b0101, 32'h17222120, 4'd11);
        // lanes 0 and 2 stuck full: beats alternate between lanes 3 and 1
        vecs[14] = mk(0, 1, 8'h30, 4'hA, 1, 1, 3, 4'b1101, 32'h30222120, 4'd12);
        vecs[15] = mk(0, 1, 8'h31, 4'hA, 1, 1, 1, 4'b0111, 32'h30223120, 4'd13);
        vecs[16] = mk(0, 1, 8'h32, 4'hA, 1, 1, 3, 4'b1101, 32'h32223120, 4'd14);
        vecs[17] = mk(0, 1, 8'h33, 4'hA, 1, 1, 1, 4'b0111, 32'h32223320, 4'd15);
        vecs[18] = mk(0, 1, 8'h34, 4'h0, 1, 1, 3, 4'b1111, 32'h34223320, 4'd0);
        // all full and stalled, then only lane 2 drains and reloads at once
        vecs[19] = mk(0, 1, 8'h35, 4'h0, 1, 0, 0, 4'b1111, 32'h34223320, 4'd0);
        vecs[20] = mk(0, 1, 8'h36, 4'h4, 1, 1, 2, 4'b1111, 32'h34363320, 4'd1);
        // pointer at lane 3, lane 3 blocked: wrap to lane 0, pointer then lane 1
        vecs[21] = mk(0, 1, 8'h37, 4'h1, 1, 1, 0, 4'b1111, 32'h34363337, 4'd2);
        vecs[22] = mk(0, 1, 8'h38, 4'hF, 1, 1, 1, 4'b0010, 32'h34363837, 4'd3);
        vecs[23] = mk(0, 1, 8'h39, 4'h0, 1, 1, 2, 4'b0110, 32'h34393837, 4'd4);
        vecs[24] = mk(1, 1, 8'h3A, 4'h0, 0, 0, 0, 4'b0000, 32'h00000000, 4'd0);
        vecs[25] = mk(0, 1, 8'h3B, 4'h0, 1, 1, 0, 4'b0001, 32'h0000003B, 4'd1);

        repeat (2) @(posedge clk);
        #1;
        check("reset_m_valid", 32'(m_valid), 32'h0);
        check("reset_m_data", m_data, 32'h0);
        check("reset_acc_cnt", 32'(acc_cnt), 32'h0);

        for (int i = 0; i < 26; i++) begin
            rst     = vecs[i].rst;
            s_valid = vecs[i].sv;
            s_data  = vecs[i].d;
            m_ready = vecs[i].mr;
            @(negedge clk);
            if (vecs[i].chk) begin
                check($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].rdy));
                if (vecs[i].rdy)
                    check($sformatf("v%0d_s_lane", i), 32'(s_lane), 32'(vecs[i].lane));
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].mv));
            check($sformatf("v%0d_m_data", i), m_data, vecs[i].md);
            check($sformatf("v%0d_acc_cnt", i), 32'(acc_cnt), 32'(vecs[i].cnt));
        end

        // 17 beats through a 4-bit counter with all consumers ready: in-order, exactly once, count wraps to 1
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("wrap_reset_acc_cnt", 32'(acc_cnt), 32'h0);
        sb_q.delete();
        for (int i = 0; i < 17; i++) begin
            s_valid = 1'b1;
            s_data  = 8'h40 + 8'(i);
            @(negedge clk);
            check($sformatf("wrap_s_ready_%0d", i), 32'(s_ready), 32'h1);
            sb_sample("wrap");
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            sb_sample("drain");
            @(posedge clk);
            #1;
        end
        check("wrap_acc_cnt", 32'(acc_cnt), 32'h1);
        check("wrap_pushed", 32'(pushed), 32'd17);
        check("wrap_popped", 32'(popped), 32'd17);
        check("wrap_leftover", 32'(sb_q.size()), 32'd0);
        check("wrap_idle_m_valid", 32'(m_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
